fsm_event_logger: RTL

- Downstream consumer of the a-sequence detector's f/g outputs.
- f is the high level during the detector's Clear phase; g is the completion level.
- Measures each f-high interval and queues completed durations in a small FIFO for a valid/ready reader.
- Keeps a wrap-around count of completed sequences and a saturating count of aborted ones.

---
 rtl/fsm_event_logger_if.sv | 12 +
 rtl/fsm_event_logger.sv | 118 +++++++++++
 2 files changed

// File: rtl/fsm_event_logger_if.sv
// Duration read port: head-of-FIFO sample with valid/ready handshake.
// The logger drives data/valid as master; the reader returns ready as slave.
interface fsm_event_logger_if #(
    parameter int DUR_W = 8
);
    logic [DUR_W-1:0] dur_data;
    logic             dur_valid;
    logic             dur_ready;

    modport master (output dur_data, output dur_valid, input dur_ready);
    modport slave  (input dur_data, input dur_valid, output dur_ready);
endinterface

// File: rtl/fsm_event_logger.sv
// Times each f-high interval of the sequence detector and queues completed durations;
// a push is visible one cycle later (no fall-through); full FIFO drops new entries unless popped.
module fsm_event_logger #(
    parameter int DUR_W   = 8,
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     f_in,
    input  logic                     g_in,
    input  logic                     clr_ovf,
    fsm_event_logger_if.master       dur,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [COUNT_W-1:0]       seq_count,
    output logic [COUNT_W-1:0]       abort_count,
    output logic                     measuring
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t             state;
    logic               f_q;
    logic               g_q;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DUR_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;

    // A completed interval ends the cycle f is sampled low while g is already high.
    assign push  = (state == MEASURE) && !f_in && g_in;
    assign pop   = dur.dur_valid && dur.dur_ready;
    assign full  = (fifo_level == LVL_W'(DEPTH));
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign dur.dur_valid = (fifo_level != '0);
    assign dur.dur_data  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            dur_cnt     <= '0;
            measuring   <= 1'b0;
            abort_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_in && !f_q) begin
                        state     <= MEASURE;
                        measuring <= 1'b1;
                        dur_cnt   <= DUR_W'(1);
                    end
                end
                MEASURE: begin
                    if (f_in) begin
                        if (dur_cnt != '1)
                            dur_cnt <= dur_cnt + DUR_W'(1);
                    end else begin
                        state     <= IDLE;
                        measuring <= 1'b0;
                        if (!g_in && abort_count != '1)
                            abort_count <= abort_count + COUNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    measuring <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            f_q       <= 1'b0;
            g_q       <= 1'b0;
            seq_count <= '0;
        end else begin
            f_q <= f_in;
            g_q <= g_in;
            if (g_in && !g_q)
                seq_count <= seq_count + COUNT_W'(1);
        end
    end

    // Level tracks both sides at once, so a push and pop while full leaves it at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= dur_cnt;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= fifo_level + LVL_W'(wr_en) - LVL_W'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule
